// File: rtl/pixels_line_scheduler_if.sv
// Bundle between the row renderer, the pixel line buffer pair, the video stage
// and the ping-pong line scheduler.
interface pixels_line_scheduler_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 64,
  parameter int ROW_WIDTH  = 11
);
  logic                  line_start;
  logic [ROW_WIDTH-1:0]  next_row;
  logic                  fill_start;
  logic [ROW_WIDTH-1:0]  fill_row;
  // src_valid/src_ready: a word moves on a rising edge where both are high;
  // src_ready never depends on src_valid, and an unaccepted word may change.
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en0;
  logic                  wr_en1;
  logic                  rd_sel;
  logic                  busy;
  logic                  underrun;
  logic [1:0]            dbg_state;

  modport master (
    output line_start, next_row, src_valid, src_data,
    input  fill_start, fill_row, src_ready, wr_addr, wr_data,
           wr_en0, wr_en1, rd_sel, busy, underrun, dbg_state
  );

  modport slave (
    input  line_start, next_row, src_valid, src_data,
    output fill_start, fill_row, src_ready, wr_addr, wr_data,
           wr_en0, wr_en1, rd_sel, busy, underrun, dbg_state
  );
endinterface

// File: rtl/pixels_line_scheduler.sv
// Ping-pong line buffer controller: video reads buffer rd_sel while the
// renderer's word stream fills the other one; line_start swaps the pair.
module pixels_line_scheduler #(
  parameter int WORDS      = 80,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 64,
  parameter int ROW_WIDTH  = 11
) (
  input logic clk,
  input logic reset,
  pixels_line_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL      = ADDR_WIDTH'(WORDS);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] count, count_nxt;
  logic                  rd_sel_q;
  logic                  fill_start_q;
  logic                  underrun_q;
  logic                  wr_en0_q;
  logic                  wr_en1_q;
  logic [ROW_WIDTH-1:0]  fill_row_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  busy_c;
  logic                  src_ready_c;
  logic                  accept;
  logic                  final_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // line_start wins over everything: any partial fill is dropped and restarted.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (bus.line_start) begin
      state_nxt = FILL;
      count_nxt = '0;
    end else if (accept) begin
      if (count != FULL) count_nxt = count + 1'b1;
      if (count == LAST_WORD) state_nxt = DONE;
    end
  end

  // The fill_start cycle gives the renderer one cycle to begin before words flow.
  always_comb begin
    busy_c      = (state == FILL);
    src_ready_c = busy_c & ~fill_start_q & ~reset;
  end

  assign accept       = bus.src_valid & src_ready_c;
  assign final_accept = accept & (count == LAST_WORD);

  // The write target is the pre-swap fill side, even when line_start coincides.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_sel_q     <= 1'b0;
      fill_row_q   <= '0;
      fill_start_q <= 1'b0;
      underrun_q   <= 1'b0;
      wr_en0_q     <= 1'b0;
      wr_en1_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      fill_start_q <= bus.line_start;
      underrun_q   <= bus.line_start & busy_c & ~final_accept;
      if (bus.line_start) begin
        rd_sel_q   <= ~rd_sel_q;
        fill_row_q <= bus.next_row;
      end
      wr_en0_q <= accept & rd_sel_q;
      wr_en1_q <= accept & ~rd_sel_q;
      if (accept) begin
        wr_addr_q <= count;
        wr_data_q <= bus.src_data;
      end
    end
  end

  assign bus.fill_start = fill_start_q;
  assign bus.fill_row   = fill_row_q;
  assign bus.src_ready  = src_ready_c;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_en0     = wr_en0_q & ~reset;
  assign bus.wr_en1     = wr_en1_q & ~reset;
  assign bus.rd_sel     = rd_sel_q;
  assign bus.busy       = busy_c;
  assign bus.underrun   = underrun_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_pixels_line_scheduler.sv
// Bench for pixels_line_scheduler: scenario tasks drive a line-level model and
// a write scoreboard; each task also checks its own scenario outcomes inline.
module tb_pixels_line_scheduler;

  localparam int WORDS = 80;

  logic clk = 1'b0;
  logic reset;

  pixels_line_scheduler_if bus ();

  pixels_line_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Line-level model: which buffer is shown, which row is wanted, how many
  // words of the current line have landed.
  bit          m_rd_sel;
  logic [10:0] m_row;
  bit          m_filling;
  bit          m_first;
  int          m_words;
  bit          m_exp_fs;
  bit          m_exp_ur;
  bit          m_exp_wr;
  bit          mon_en = 1'b0;

  logic [71:0] exp_q[$];

  int wr_cnt0 = 0;
  int wr_cnt1 = 0;
  int ur_cnt  = 0;
  int fs_cnt  = 0;

  task automatic step(input bit rst, input bit ls, input logic [10:0] row,
                      input bit v, input logic [63:0] d);
    bit acc;
    reset          = rst;
    bus.line_start = ls;
    bus.next_row   = row;
    bus.src_valid  = v;
    bus.src_data   = d;
    acc = !rst && v && m_filling && !m_first && (m_words < WORDS);
    m_exp_wr = acc;
    if (rst) begin
      m_rd_sel = 1'b0; m_row = '0; m_filling = 1'b0; m_first = 1'b0;
      m_words = 0; m_exp_fs = 1'b0; m_exp_ur = 1'b0;
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back({~m_rd_sel, 7'(m_words), d});
      m_exp_ur = ls && m_filling && !(acc && m_words == WORDS - 1);
      m_exp_fs = ls;
      if (ls) begin
        m_rd_sel = ~m_rd_sel; m_row = row; m_filling = 1'b1;
        m_first = 1'b1; m_words = 0;
      end else begin
        m_first = 1'b0;
        if (acc) begin
          m_words++;
          if (m_words == WORDS) m_filling = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: valid every cycle with data = word index; 1: valid toggling with
  // random data; 2: random valid with random data.
  task automatic drive_words(input int n, input int mode, output bit timed_out);
    int target;
    int budget;
    bit v;
    logic [63:0] d;
    target = m_words + n;
    budget = 0;
    while (m_words < target && budget < 400) begin
      if (mode == 0) begin
        v = 1'b1;
        d = 64'(m_words);
      end else begin
        v = (mode == 1) ? (budget % 2 == 0) : ($urandom_range(0, 3) != 0);
        d = {$urandom, $urandom};
      end
      step(1'b0, 1'b0, '0, v, d);
      budget++;
    end
    timed_out = (m_words < target);
  endtask

  // Scoreboard: every cycle, after the edge, compare registered outputs to the model.
  always @(posedge clk) begin
    logic [71:0] got;
    logic [71:0] exp;
    #1;
    if (mon_en) begin
      n_tests++;
      if (bus.wr_en0 && bus.wr_en1) begin
        n_fail++;
        $display("FAIL both_wr_en: wr_en0=%b wr_en1=%b, required at most one", bus.wr_en0, bus.wr_en1);
      end
      n_tests++;
      if ((bus.wr_en0 | bus.wr_en1) !== m_exp_wr) begin
        n_fail++;
        $display("FAIL write_present: got %b required %b at t=%0t", bus.wr_en0 | bus.wr_en1, m_exp_wr, $time);
      end else if (m_exp_wr && exp_q.size() > 0) begin
        got = {bus.wr_en1, bus.wr_addr, bus.wr_data};
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL write_word: got buffer=%0d addr=%0d data=%h required buffer=%0d addr=%0d data=%h",
                   got[71], got[70:64], got[63:0], exp[71], exp[70:64], exp[63:0]);
        end
      end
      n_tests++;
      if (bus.fill_start !== m_exp_fs) begin
        n_fail++;
        $display("FAIL fill_start: got %b required %b at t=%0t", bus.fill_start, m_exp_fs, $time);
      end
      n_tests++;
      if (bus.underrun !== m_exp_ur) begin
        n_fail++;
        $display("FAIL underrun: got %b required %b at t=%0t", bus.underrun, m_exp_ur, $time);
      end
      n_tests++;
      if (bus.rd_sel !== m_rd_sel || bus.busy !== m_filling || bus.fill_row !== m_row) begin
        n_fail++;
        $display("FAIL line_status: got rd_sel=%b busy=%b row=%0d required rd_sel=%b busy=%b row=%0d",
                 bus.rd_sel, bus.busy, bus.fill_row, m_rd_sel, m_filling, m_row);
      end
      if (bus.wr_en0) wr_cnt0++;
      if (bus.wr_en1) wr_cnt1++;
      if (bus.underrun) ur_cnt++;
      if (bus.fill_start) fs_cnt++;
    end
  end

  task automatic test_reset();
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b1, 64'hdead_beef);
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, {$urandom, $urandom});
    n_tests++;
    if ({bus.rd_sel, bus.busy, bus.src_ready, bus.wr_en0, bus.wr_en1, bus.underrun} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rd_sel,busy,ready,en0,en1,underrun=%b required 000000",
               {bus.rd_sel, bus.busy, bus.src_ready, bus.wr_en0, bus.wr_en1, bus.underrun});
    end
  endtask

  task automatic test_full_fill();
    int c0, c1, u;
    bit to;
    c0 = wr_cnt0; c1 = wr_cnt1; u = ur_cnt;
    step(1'b0, 1'b1, 11'd5, 1'b1, 64'd0);
    n_tests++;
    if ({bus.fill_start, bus.rd_sel, bus.src_ready} !== 3'b110 || bus.fill_row !== 11'd5) begin
      n_fail++;
      $display("FAIL full_start: fill_start,rd_sel,ready=%b row=%0d required 110 row=5",
               {bus.fill_start, bus.rd_sel, bus.src_ready}, bus.fill_row);
    end
    drive_words(WORDS, 0, to);
    n_tests++;
    if (to || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: timed_out=%b busy=%b required 0 0", to, bus.busy);
    end
    step(1'b0, 1'b0, '0, 1'b0, '0);
    n_tests++;
    if (wr_cnt0 - c0 != WORDS || wr_cnt1 != c1 || ur_cnt != u || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_counts: en0=%0d en1=%0d underruns=%0d pending=%0d required 80 0 0 0",
               wr_cnt0 - c0, wr_cnt1 - c1, ur_cnt - u, exp_q.size());
    end
  endtask

  task automatic test_toggle_fill();
    int c0, c1;
    bit to;
    step(1'b0, 1'b1, 11'($urandom_range(0, 2047)), 1'b0, '0);
    c0 = wr_cnt0; c1 = wr_cnt1;
    drive_words(WORDS, 1, to);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (bus.src_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL done_ready: got %b required 0", bus.src_ready);
      end
      step(1'b0, 1'b0, '0, 1'b1, {$urandom, $urandom});
    end
    n_tests++;
    if (to || wr_cnt1 - c1 != WORDS || wr_cnt0 != c0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL toggle_counts: timed_out=%b en1=%0d en0=%0d pending=%0d required 0 80 0 0",
               to, wr_cnt1 - c1, wr_cnt0 - c0, exp_q.size());
    end
  endtask

  task automatic test_underrun();
    bit to, to2, rd_before;
    logic [10:0] row;
    logic [63:0] d;
    step(1'b0, 1'b1, 11'($urandom_range(0, 2047)), 1'b0, '0);
    drive_words(40, 2, to);
    rd_before = m_rd_sel;
    row = 11'($urandom_range(0, 2047));
    step(1'b0, 1'b1, row, 1'b0, '0);
    n_tests++;
    if (bus.underrun !== 1'b1 || bus.rd_sel !== ~rd_before || bus.fill_row !== row) begin
      n_fail++;
      $display("FAIL underrun_pulse: underrun=%b rd_sel=%b row=%0d required 1 %b %0d",
               bus.underrun, bus.rd_sel, bus.fill_row, ~rd_before, row);
    end
    step(1'b0, 1'b0, '0, 1'b0, '0);
    n_tests++;
    if (bus.underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_width: got %b required 0", bus.underrun);
    end
    d = {$urandom, $urandom};
    step(1'b0, 1'b0, '0, 1'b1, d);
    n_tests++;
    if ({bus.wr_en1, bus.wr_en0} !== 2'b10 || bus.wr_addr !== 7'd0 || bus.wr_data !== d) begin
      n_fail++;
      $display("FAIL restart_write: en1,en0=%b addr=%0d data=%h required 10 0 %h",
               {bus.wr_en1, bus.wr_en0}, bus.wr_addr, bus.wr_data, d);
    end
    drive_words(WORDS - 1, 2, to2);
    n_tests++;
    if (to || to2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL underrun_fill: timed_out=%b/%b pending=%0d required 0/0 0", to, to2, exp_q.size());
    end
  endtask

  task automatic test_coincident();
    bit to, to2, r;
    int u;
    step(1'b0, 1'b1, 11'($urandom_range(0, 2047)), 1'b0, '0);
    drive_words(WORDS - 1, 0, to);
    u = ur_cnt;
    r = m_rd_sel;
    step(1'b0, 1'b1, 11'($urandom_range(0, 2047)), 1'b1, 64'd79);
    n_tests++;
    if (bus.underrun !== 1'b0 || ur_cnt != u || bus.wr_addr !== 7'd79 || bus.wr_data !== 64'd79 ||
        {bus.wr_en1, bus.wr_en0} !== (r ? 2'b01 : 2'b10)) begin
      n_fail++;
      $display("FAIL coincident_last: underrun=%b addr=%0d data=%0d en1,en0=%b required 0 79 79 %b",
               bus.underrun, bus.wr_addr, bus.wr_data, {bus.wr_en1, bus.wr_en0}, r ? 2'b01 : 2'b10);
    end
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, 64'h1234);
    n_tests++;
    if ({bus.wr_en1, bus.wr_en0} !== (r ? 2'b10 : 2'b01) || bus.wr_addr !== 7'd0) begin
      n_fail++;
      $display("FAIL coincident_next: en1,en0=%b addr=%0d required %b 0",
               {bus.wr_en1, bus.wr_en0}, bus.wr_addr, r ? 2'b10 : 2'b01);
    end
    drive_words(WORDS - 1, 2, to2);
    n_tests++;
    if (to || to2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL coincident_fill: timed_out=%b/%b pending=%0d required 0/0 0", to, to2, exp_q.size());
    end
  endtask

  task automatic test_reset_midfill();
    bit to, to2;
    int c0, c1;
    step(1'b0, 1'b1, 11'($urandom_range(0, 2047)), 1'b0, '0);
    drive_words(30, 0, to);
    step(1'b1, 1'b0, '0, 1'b1, 64'd30);
    n_tests++;
    if (bus.rd_sel !== 1'b0 || bus.busy !== 1'b0 || bus.wr_en0 !== 1'b0 || bus.wr_en1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midfill: rd_sel=%b busy=%b en0=%b en1=%b required 0 0 0 0",
               bus.rd_sel, bus.busy, bus.wr_en0, bus.wr_en1);
    end
    c0 = wr_cnt0; c1 = wr_cnt1;
    step(1'b0, 1'b0, '0, 1'b1, 64'd31);
    step(1'b0, 1'b1, 11'd5, 1'b1, 64'd0);
    n_tests++;
    if (bus.rd_sel !== 1'b1 || bus.fill_row !== 11'd5 || bus.fill_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_refill_start: rd_sel=%b row=%0d fill_start=%b required 1 5 1",
               bus.rd_sel, bus.fill_row, bus.fill_start);
    end
    drive_words(WORDS, 0, to2);
    n_tests++;
    if (to || to2 || wr_cnt0 - c0 != WORDS || wr_cnt1 != c1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_refill: timed_out=%b/%b en0=%0d en1=%0d busy=%b required 0/0 80 0 0",
               to, to2, wr_cnt0 - c0, wr_cnt1 - c1, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    bit to, rd_before;
    int f, u;
    logic [10:0] row;
    rd_before = m_rd_sel;
    f = fs_cnt; u = ur_cnt;
    row = '0;
    for (int i = 0; i < 3; i++) begin
      row = 11'($urandom_range(0, 2047));
      step(1'b0, 1'b1, row, 1'b1, {$urandom, $urandom});
    end
    step(1'b0, 1'b0, '0, 1'b0, '0);
    n_tests++;
    if (fs_cnt - f != 3 || ur_cnt - u != 2 || bus.rd_sel !== ~rd_before || bus.fill_row !== row) begin
      n_fail++;
      $display("FAIL back_to_back: fill_starts=%0d underruns=%0d rd_sel=%b row=%0d required 3 2 %b %0d",
               fs_cnt - f, ur_cnt - u, bus.rd_sel, bus.fill_row, ~rd_before, row);
    end
    drive_words(WORDS, 2, to);
    n_tests++;
    if (to || bus.busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL back_to_back_fill: timed_out=%b busy=%b pending=%0d required 0 0 0",
               to, bus.busy, exp_q.size());
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.line_start = 1'b0;
    bus.next_row   = '0;
    bus.src_valid  = 1'b0;
    bus.src_data   = '0;
    test_reset();
    test_full_fill();
    test_toggle_fill();
    test_underrun();
    test_coincident();
    test_reset_midfill();
    test_back_to_back();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
